noc_credit_sender: RTL and testbench

Credit-based flit sender that sits directly upstream of one dynamic-node router input port (N/E/S/W/P) and drives that port's dataIn/validIn pair. It accepts 64-bit flits from a local producer over a valid/ready handshake, buffers them, and launches one flit per cycle only while it holds a credit. Credits are returned one per pulse on the router's yummyOut for the same direction.

---
 rtl/noc_credit_sender_pkg.sv | 23 ++
 rtl/noc_credit_sender_if.sv | 23 ++
 rtl/noc_sync_fifo.sv | 52 +++++
 rtl/noc_credit_sender.sv | 85 ++++++++
 tb/tb_noc_credit_sender.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/noc_credit_sender_pkg.sv
// rtl/noc_credit_sender_pkg.sv - shared NoC widths, credit event encoding and width helper
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

package noc_credit_sender_pkg;

  localparam int FLIT_WIDTH     = `DATA_WIDTH;
  localparam int DEF_CREDITS    = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    CR_HOLD,
    CR_TAKE,
    CR_RETURN,
    CR_OVERFLOW
  } credit_evt_e;

  function automatic int credit_width(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/noc_credit_sender_if.sv
// rtl/noc_credit_sender_if.sv - producer handshake plus router dataIn/validIn/yummyOut bundle
interface noc_credit_sender_if
  import noc_credit_sender_pkg::*;
#(
  parameter int DATA_WIDTH = FLIT_WIDTH
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_val;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  validOut;
  logic                  yummyIn;

  modport master (
    output in_data, in_val, yummyIn,
    input  in_rdy, dataOut, validOut
  );

  modport slave (
    input  in_data, in_val, yummyIn,
    output in_rdy, dataOut, validOut
  );
endinterface

// File: rtl/noc_sync_fifo.sv
// rtl/noc_sync_fifo.sv - parameterized synchronous FIFO, power-of-two depth
module noc_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/noc_credit_sender.sv
// rtl/noc_credit_sender.sv - credit-gated flit launcher feeding one dynamic-node router input port
module noc_credit_sender
  import noc_credit_sender_pkg::*;
#(
  parameter int DATA_WIDTH = FLIT_WIDTH,
  parameter int CREDITS    = DEF_CREDITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset_in,
  noc_credit_sender_if.slave               bus,
  output logic [credit_width(CREDITS)-1:0] credit_cnt,
  output logic                             credit_err
);
  localparam int CW  = credit_width(CREDITS);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]  MAX_CREDITS = CW'(CREDITS);
  localparam logic [FCW-1:0] FIFO_FULL   = FCW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FCW-1:0]        fifo_count;
  logic [FCW-1:0]        fifo_next;
  logic                  accept;
  logic                  send;
  credit_evt_e           evt;

  assign accept = bus.in_val && bus.in_rdy && !fifo_full;
  assign send   = !fifo_empty && (credit_cnt != '0);

  noc_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset_in),
    .push      (accept),
    .push_data (bus.in_data),
    .pop       (send),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    evt = CR_HOLD;
    if (send && !bus.yummyIn) begin
      evt = CR_TAKE;
    end else if (!send && bus.yummyIn) begin
      evt = (credit_cnt == MAX_CREDITS) ? CR_OVERFLOW : CR_RETURN;
    end
  end

  always_comb begin
    fifo_next = fifo_count;
    case ({accept, send})
      2'b10:   fifo_next = fifo_count + 1'b1;
      2'b01:   fifo_next = fifo_count - 1'b1;
      default: fifo_next = fifo_count;
    endcase
  end

  // in_rdy tracks next-cycle occupancy, so a pop while full reopens it one cycle later.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      bus.dataOut  <= '0;
      bus.validOut <= 1'b0;
      bus.in_rdy   <= 1'b0;
      credit_cnt   <= MAX_CREDITS;
      credit_err   <= 1'b0;
    end else begin
      bus.validOut <= send;
      if (send) bus.dataOut <= head;
      bus.in_rdy <= (fifo_next != FIFO_FULL);
      case (evt)
        CR_TAKE:     credit_cnt <= credit_cnt - 1'b1;
        CR_RETURN:   credit_cnt <= credit_cnt + 1'b1;
        CR_OVERFLOW: credit_err <= 1'b1;
        default:     credit_cnt <= credit_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_noc_credit_sender.sv
// tb/tb_noc_credit_sender.sv - directed table and sequence bench for noc_credit_sender
module tb_noc_credit_sender;

  typedef struct {
    logic        rst;
    logic        val;
    logic [63:0] data;
    logic        yummy;
    logic        e_valid;
    logic [63:0] e_data;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic        e_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_in;
  logic [2:0] credit_cnt;
  logic       credit_err;

  int checks = 0;
  int errors = 0;

  noc_credit_sender_if #(.DATA_WIDTH(64)) bus ();

  noc_credit_sender #(
    .DATA_WIDTH (64),
    .CREDITS    (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset_in   (reset_in),
    .bus        (bus),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] A  = 64'hDEADBEEF_00000001;
  localparam logic [63:0] B0 = 64'h00000000_B0000000;

  vec_t        vecs [26];
  logic [63:0] base;
  logic [2:0]  hist;
  logic        rdy_before;
  logic        drive_val;
  logic [2:0]  max_cnt;
  int          sent;
  int          recv;
  int          cyc;

  function automatic vec_t mk(input logic r, v, input logic [63:0] d, input logic y,
                              input logic ev, input logic [63:0] ed, input logic [2:0] ec,
                              input logic er, input logic ee);
    vec_t t;
    t.rst = r; t.val = v; t.data = d; t.yummy = y;
    t.e_valid = ev; t.e_data = ed; t.e_cnt = ec; t.e_rdy = er; t.e_err = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [63:0] d, input logic y);
    reset_in     = r;
    bus.in_val   = v;
    bus.in_data  = d;
    bus.yummyIn  = y;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [63:0] ed,
                         input logic [2:0] ec, input logic er);
    chk({tag, ".valid"}, 64'(bus.validOut), 64'(ev));
    if (ev) chk({tag, ".data"}, bus.dataOut, ed);
    chk({tag, ".cnt"}, 64'(credit_cnt), 64'(ec));
    chk({tag, ".rdy"}, 64'(bus.in_rdy), 64'(er));
  endtask

  initial begin
    reset_in    = 1'b1;
    bus.in_val  = 1'b0;
    bus.in_data = '0;
    bus.yummyIn = 1'b0;

    // rst val data yummy | valid data cnt rdy err
    vecs[0]  = mk(1, 1, A,     0, 0, 64'd0,  3'd4, 0, 0);
    vecs[1]  = mk(1, 1, A,     0, 0, 64'd0,  3'd4, 0, 0);
    vecs[2]  = mk(1, 1, A,     0, 0, 64'd0,  3'd4, 0, 0);
    vecs[3]  = mk(0, 0, 64'd0, 0, 0, 64'd0,  3'd4, 1, 0);
    vecs[4]  = mk(0, 1, A,     0, 0, 64'd0,  3'd4, 1, 0);
    vecs[5]  = mk(0, 0, 64'd0, 0, 1, A,      3'd3, 1, 0);
    vecs[6]  = mk(0, 0, 64'd0, 1, 0, A,      3'd4, 1, 0);
    vecs[7]  = mk(0, 1, B0+0,  0, 0, A,      3'd4, 1, 0);
    vecs[8]  = mk(0, 1, B0+1,  0, 1, B0+0,   3'd3, 1, 0);
    vecs[9]  = mk(0, 1, B0+2,  0, 1, B0+1,   3'd2, 1, 0);
    vecs[10] = mk(0, 1, B0+3,  0, 1, B0+2,   3'd1, 1, 0);
    vecs[11] = mk(0, 1, B0+4,  0, 1, B0+3,   3'd0, 1, 0);
    vecs[12] = mk(0, 1, B0+5,  0, 0, B0+3,   3'd0, 1, 0);
    vecs[13] = mk(0, 0, 64'd0, 0, 0, B0+3,   3'd0, 1, 0);
    vecs[14] = mk(0, 0, 64'd0, 1, 0, B0+3,   3'd1, 1, 0);
    vecs[15] = mk(0, 0, 64'd0, 0, 1, B0+4,   3'd0, 1, 0);
    vecs[16] = mk(0, 0, 64'd0, 0, 0, B0+4,   3'd0, 1, 0);
    vecs[17] = mk(0, 0, 64'd0, 1, 0, B0+4,   3'd1, 1, 0);
    vecs[18] = mk(0, 0, 64'd0, 1, 1, B0+5,   3'd1, 1, 0);
    vecs[19] = mk(0, 0, 64'd0, 1, 0, B0+5,   3'd2, 1, 0);
    vecs[20] = mk(0, 0, 64'd0, 1, 0, B0+5,   3'd3, 1, 0);
    vecs[21] = mk(0, 0, 64'd0, 1, 0, B0+5,   3'd4, 1, 0);
    vecs[22] = mk(0, 0, 64'd0, 1, 0, B0+5,   3'd4, 1, 1);
    vecs[23] = mk(0, 0, 64'd0, 0, 0, B0+5,   3'd4, 1, 1);
    vecs[24] = mk(1, 0, 64'd0, 0, 0, 64'd0,  3'd4, 0, 0);
    vecs[25] = mk(0, 0, 64'd0, 0, 0, 64'd0,  3'd4, 1, 0);

    for (int i = 0; i < 26; i++) begin
      step(vecs[i].rst, vecs[i].val, vecs[i].data, vecs[i].yummy);
      chk($sformatf("vec%0d.valid", i), 64'(bus.validOut), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d.data", i), bus.dataOut, vecs[i].e_data);
      chk($sformatf("vec%0d.cnt", i), 64'(credit_cnt), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d.rdy", i), 64'(bus.in_rdy), 64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d.err", i), 64'(credit_err), 64'(vecs[i].e_err));
    end

    // Send coinciding with a credit return at credit_cnt == 2.
    step(0, 1, 64'hF0, 0); chk_out("sim0", 0, 64'd0, 3'd4, 1);
    step(0, 1, 64'hF1, 0); chk_out("sim1", 1, 64'hF0, 3'd3, 1);
    step(0, 1, 64'hF2, 0); chk_out("sim2", 1, 64'hF1, 3'd2, 1);
    step(0, 0, 64'd0, 1);  chk_out("sim3", 1, 64'hF2, 3'd2, 1);

    // Fill the FIFO with no credits, reopen it, then reset with flits buffered.
    step(1, 0, 64'd0, 0);
    step(1, 0, 64'd0, 0);
    step(0, 0, 64'd0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 64'hC000_0000_0000_0000 + 64'(i), 0);
    chk_out("full", 0, 64'd0, 3'd0, 0);
    step(0, 1, 64'hBAD, 1); chk_out("full_yummy", 0, 64'd0, 3'd1, 0);
    step(0, 1, 64'hBAD, 0); chk_out("full_pop", 1, 64'hC000_0000_0000_0004, 3'd0, 1);
    step(0, 0, 64'd0, 1);   chk_out("pre_rst", 0, 64'd0, 3'd1, 1);
    step(1, 1, 64'hBAD, 0); chk_out("mid_rst0", 0, 64'd0, 3'd4, 0);
    chk("mid_rst0.data", bus.dataOut, 64'd0);
    step(1, 1, 64'hBAD, 1); chk_out("mid_rst1", 0, 64'd0, 3'd4, 0);
    chk("mid_rst1.err", 64'(credit_err), 64'd0);
    step(0, 0, 64'd0, 0);   chk_out("post_rst0", 0, 64'd0, 3'd4, 1);
    step(0, 0, 64'd0, 0);   chk_out("post_rst1", 0, 64'd0, 3'd4, 1);
    step(0, 1, 64'h2222, 0); chk_out("post_rst2", 0, 64'd0, 3'd4, 1);
    step(0, 0, 64'd0, 0);   chk_out("post_rst3", 1, 64'h2222, 3'd3, 1);

    // 100-flit stream with yummyIn echoing validOut three cycles later.
    step(1, 0, 64'd0, 0);
    step(0, 0, 64'd0, 0);
    base    = 64'h5000_0000_0000_0000;
    hist    = 3'b000;
    sent    = 0;
    recv    = 0;
    cyc     = 0;
    max_cnt = credit_cnt;
    while (recv < 100 && cyc < 2000) begin
      rdy_before = bus.in_rdy;
      drive_val  = (sent < 100);
      step(0, drive_val, base + 64'(sent), hist[2]);
      if (drive_val && rdy_before) sent++;
      hist = {hist[1:0], bus.validOut};
      if (bus.validOut) begin
        chk($sformatf("stream.data%0d", recv), bus.dataOut, base + 64'(recv));
        recv++;
      end
      if (credit_cnt > max_cnt) max_cnt = credit_cnt;
      cyc++;
    end
    chk("stream.received", 64'(recv), 64'd100);
    chk("stream.cnt_le_4", 64'(max_cnt > 3'd4), 64'd0);
    chk("stream.err", 64'(credit_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
